tx_fifo_stage_idle_n: RTL and testbench

- Parametrised N-entry holding stage between the TX FIFO read side and the escaper.
- Generalises the fixed 2-entry idle stage with:
  - configurable depth;
  - configurable skid headroom for the upstream idle handshake;
  - simultaneous push/pop;
  - a sticky overflow flag.
- Data is advanced only on cycles where in_enable is high, and is presented to the escaper only while the escaper reports in_idle.

---
 rtl/tx_fifo_stage_idle_n.sv | 161 ++++++++++++++++
 tb/tb_tx_fifo_stage_idle_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_stage_idle_n.sv
`default_nettype none
// ============================================================================
//  Module   : tx_fifo_stage_idle_n
//  Purpose  : N-entry holding stage between the TX FIFO read side and the
//             escaper. Circular buffer with skid headroom on the upstream
//             ready (out_idle), same-cycle push/pop, and a sticky overflow
//             flag for writes that arrive while the stage is full.
//  Options  : `define TX_STAGE_LEVEL_EN to expose the fill level on
//             out_level (width $clog2(DEPTH)+1, equal to the entry count).
//  Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_stage_idle_n #(
  parameter int unsigned WR_WIDTH = 12,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SKID     = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_enable,
  input  logic                      in_en,
  input  logic [WR_WIDTH-1:0]       in_data,
  output logic                      out_idle,
  output logic                      out_en,
  output logic [WR_WIDTH-1:0]       out_data,
  input  logic                      in_idle,
  output logic                      ovf
`ifdef TX_STAGE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]    out_level
`endif
);

  // Pointer and occupancy widths. The count needs one extra bit so that a
  // full stage (count == DEPTH) is distinguishable from an empty one.
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(DEPTH - SKID);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  // Read view of the storage entries, one slice per entry.
  logic [DEPTH-1:0][WR_WIDTH-1:0] mem_rd;

  // Handshake qualifiers for this cycle.
  logic is_empty;
  logic is_full;
  logic pop;
  logic push;
  logic drop;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_COUNT);

  // The escaper only samples on enabled cycles, so out_en itself is not
  // gated by in_enable; the pop that consumes the head word is.
  assign out_en   = !is_empty && in_idle;
  assign out_data = mem_rd[rd_ptr_q];

  // Ready to the FIFO leaves SKID entries free for words already in flight.
  assign out_idle = (count_q <= IDLE_LIMIT);

  assign pop  = in_enable && out_en;
  // A full stage can still take a word when the head leaves the same cycle.
  assign push = in_enable && in_en && (!is_full || pop);
  assign drop = in_enable && in_en && is_full && !pop;

  // --------------------------------------------------------------------------
  // Storage entries: each entry loads only when it is the write target of an
  // accepted push, otherwise it keeps its value (including while disabled).
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WR_WIDTH-1:0] entry_q, entry_d;

    // Next value for this entry: capture the incoming word on a push here.
    always_comb begin
      entry_d = entry_q;
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        entry_d = in_data;
      end
    end

    // Entry register; cleared on reset so out_data reads zero afterwards.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign mem_rd[gi] = entry_q;
  end

  // --------------------------------------------------------------------------
  // Next-state for pointers, occupancy and the sticky overflow flag.
  // push/pop/drop are already qualified by in_enable, so a disabled cycle
  // falls through to "hold" for every register.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    // A dropped word only marks the flag; it never clears until reset.
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Control registers; reset discards every held word without flushing.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;

`ifdef TX_STAGE_LEVEL_EN
  // Fill level mirrors the occupancy register directly.
  assign out_level = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_stage_idle_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_fifo_stage_idle_n
//  Purpose  : Directed self-checking bench for tx_fifo_stage_idle_n with
//             DEPTH=4, SKID=1, WR_WIDTH=12. Checks out_level as well when
//             TX_STAGE_LEVEL_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_stage_idle_n;

  localparam int unsigned WR_WIDTH = 12;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned SKID     = 1;

  logic                clock;
  logic                reset_n;
  logic                in_enable;
  logic                in_en;
  logic [WR_WIDTH-1:0] in_data;
  logic                out_idle;
  logic                out_en;
  logic [WR_WIDTH-1:0] out_data;
  logic                in_idle;
  logic                ovf;
`ifdef TX_STAGE_LEVEL_EN
  logic [2:0]          out_level;
`endif

  int n_vec;
  int n_err;

  tx_fifo_stage_idle_n #(
    .WR_WIDTH (WR_WIDTH),
    .DEPTH    (DEPTH),
    .SKID     (SKID)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_enable (in_enable),
    .in_en     (in_en),
    .in_data   (in_data),
    .out_idle  (out_idle),
    .out_en    (out_en),
    .out_data  (out_data),
    .in_idle   (in_idle),
    .ovf       (ovf)
`ifdef TX_STAGE_LEVEL_EN
    ,
    .out_level (out_level)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef TX_STAGE_LEVEL_EN
    check_vec(tag, 32'(out_level), 32'(exp));
`endif
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    in_enable = 1'b1;
    in_en     = 1'b0;
    in_data   = '0;
    in_idle   = 1'b0;

    // Reset then idle
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_vec("rst_out_idle", 32'(out_idle), 32'd1);
    check_vec("rst_out_en",   32'(out_en),   32'd0);
    check_vec("rst_out_data", 32'(out_data), 32'h000);
    check_vec("rst_ovf",      32'(ovf),      32'd0);
    check_level("rst_level", 0);

    // Fill with escaper stalled: out_idle stays high up to count 3
    for (int i = 1; i <= 4; i++) begin
      in_en   = 1'b1;
      in_data = 12'(i);
      tick();
      check_vec($sformatf("fill_out_idle_%0d", i), 32'(out_idle), (i <= 3) ? 32'd1 : 32'd0);
      check_vec($sformatf("fill_out_en_%0d", i),   32'(out_en),   32'd0);
    end
    check_vec("fill_ovf",  32'(ovf),      32'd0);
    check_vec("fill_head", 32'(out_data), 32'h001);
    check_level("fill_level", 4);

    // Overflow: write while full and stalled is dropped, flag sticks
    in_en   = 1'b1;
    in_data = 12'hABC;
    tick();
    check_vec("ovf_set", 32'(ovf), 32'd1);
    in_en = 1'b0;
    tick();
    check_vec("ovf_sticky",    32'(ovf),      32'd1);
    check_vec("ovf_head_kept", 32'(out_data), 32'h001);
    check_level("ovf_level", 4);

    // Clock enable low: state frozen, out_en still follows in_idle
    in_enable = 1'b0;
    in_en     = 1'b1;
    in_data   = 12'h555;
    in_idle   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec($sformatf("ce_out_en_%0d", i),   32'(out_en),   32'd1);
      check_vec($sformatf("ce_out_data_%0d", i), 32'(out_data), 32'h001);
    end
    check_vec("ce_out_idle", 32'(out_idle), 32'd0);
    check_level("ce_level", 4);
    in_idle = 1'b0;
    #1;
    check_vec("ce_out_en_stall", 32'(out_en), 32'd0);

    // Full with simultaneous push and pop: stream 0x005..0x00C
    in_enable = 1'b1;
    in_idle   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_en   = 1'b1;
      in_data = 12'(5 + k);
      #1;
      check_vec($sformatf("pp_out_en_%0d", k),   32'(out_en),   32'd1);
      check_vec($sformatf("pp_out_data_%0d", k), 32'(out_data), 32'(1 + k));
      tick();
      check_vec($sformatf("pp_out_idle_%0d", k), 32'(out_idle), 32'd0);
    end
    check_level("pp_level", 4);

    // Drain: continues 0x009..0x00C, 0xABC never appears
    in_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec($sformatf("dr_out_en_%0d", k),   32'(out_en),   32'd1);
      check_vec($sformatf("dr_out_data_%0d", k), 32'(out_data), 32'(9 + k));
      tick();
    end
    check_vec("dr_empty_out_en",   32'(out_en),   32'd0);
    check_vec("dr_empty_out_idle", 32'(out_idle), 32'd1);
    check_vec("dr_ovf_still",      32'(ovf),      32'd1);
    check_level("dr_level", 0);

    // Empty with in_en high: push only, no same-cycle pass-through
    in_en   = 1'b1;
    in_data = 12'h00D;
    #1;
    check_vec("empty_push_out_en", 32'(out_en), 32'd0);
    tick();
    check_vec("empty_lat_out_en",   32'(out_en),   32'd1);
    check_vec("empty_lat_out_data", 32'(out_data), 32'h00D);

    // Build count 3 with escaper stalled
    in_idle = 1'b0;
    in_data = 12'h00E;
    tick();
    in_data = 12'h00F;
    tick();
    in_en = 1'b0;
    check_vec("c3_out_idle", 32'(out_idle), 32'd1);
    check_vec("c3_out_data", 32'(out_data), 32'h00D);
    check_level("c3_level", 3);

    // Reset mid-stream discards everything
    reset_n = 1'b0;
    in_idle = 1'b1;
    tick();
    reset_n = 1'b1;
    check_vec("mrst_out_en",   32'(out_en),   32'd0);
    check_vec("mrst_out_idle", 32'(out_idle), 32'd1);
    check_vec("mrst_out_data", 32'(out_data), 32'h000);
    check_vec("mrst_ovf",      32'(ovf),      32'd0);
    check_level("mrst_level", 0);
    tick();
    check_vec("mrst_stays_empty", 32'(out_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
